// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - register-file issue/writeback sequencer for a combinational ALU
module alu_cmd_sequencer #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_op,
    input  logic [REG_AW-1:0] cmd_rd,
    input  logic [REG_AW-1:0] cmd_rs1,
    input  logic [REG_AW-1:0] cmd_rs2,
    input  logic              cmd_use_imm,
    input  logic              cmd_load,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_ctrl,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_zero,
    output logic [REG_AW-1:0] res_rd,
    output logic              res_illegal
);
    localparam int NREGS = 1 << REG_AW;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] rf [NREGS];

    logic [REG_AW-1:0] lat_rd;
    logic              lat_load;
    logic              lat_illegal;
    logic [DATA_W-1:0] lat_imm;

    logic [DATA_W-1:0] rs1_val;
    logic [DATA_W-1:0] rs2_val;
    logic [DATA_W-1:0] exec_data;
    logic              exec_zero;

    // Register 0 is hardwired to zero on the read side; writes to it are simply skipped.
    assign rs1_val = (cmd_rs1 == '0) ? '0 : rf[cmd_rs1];
    assign rs2_val = (cmd_rs2 == '0) ? '0 : rf[cmd_rs2];

    assign cmd_ready = (state == IDLE);
    assign res_valid = (state == RESP);

    always_comb begin
        exec_data = alu_result;
        exec_zero = alu_zero;
        if (lat_illegal) begin
            exec_data = '0;
            exec_zero = 1'b1;
        end else if (lat_load) begin
            exec_data = lat_imm;
            exec_zero = (lat_imm == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            for (int i = 0; i < NREGS; i++) begin
                rf[i] <= '0;
            end
            alu_a       <= '0;
            alu_b       <= '0;
            alu_ctrl    <= 4'b0000;
            res_data    <= '0;
            res_zero    <= 1'b0;
            res_rd      <= '0;
            res_illegal <= 1'b0;
            lat_rd      <= '0;
            lat_load    <= 1'b0;
            lat_illegal <= 1'b0;
            lat_imm     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        alu_a       <= rs1_val;
                        alu_b       <= cmd_use_imm ? cmd_imm : rs2_val;
                        alu_ctrl    <= cmd_load ? 4'b0000 : cmd_op;
                        lat_rd      <= cmd_rd;
                        lat_load    <= cmd_load;
                        lat_imm     <= cmd_imm;
                        lat_illegal <= cmd_op[3] & ~cmd_load;
                        state       <= EXEC;
                    end
                end
                EXEC: begin
                    res_data    <= exec_data;
                    res_zero    <= exec_zero;
                    res_rd      <= lat_rd;
                    res_illegal <= lat_illegal;
                    if (!lat_illegal && lat_rd != '0) begin
                        rf[lat_rd] <= exec_data;
                    end
                    state <= RESP;
                end
                RESP: begin
                    if (res_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - directed self-checking bench for alu_cmd_sequencer
module tb_alu_cmd_sequencer;
    localparam int DATA_W = 32;
    localparam int REG_AW = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [3:0]        cmd_op;
    logic [REG_AW-1:0] cmd_rd;
    logic [REG_AW-1:0] cmd_rs1;
    logic [REG_AW-1:0] cmd_rs2;
    logic              cmd_use_imm;
    logic              cmd_load;
    logic [DATA_W-1:0] cmd_imm;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [3:0]        alu_ctrl;
    logic [DATA_W-1:0] alu_result;
    logic              alu_zero;
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
    logic              res_zero;
    logic [REG_AW-1:0] res_rd;
    logic              res_illegal;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
        .cmd_use_imm(cmd_use_imm), .cmd_load(cmd_load), .cmd_imm(cmd_imm),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_zero(res_zero), .res_rd(res_rd), .res_illegal(res_illegal)
    );

    // Behavioural stand-in for the downstream combinational ALU.
    always_comb begin
        case (alu_ctrl)
            4'b0000: alu_result = alu_a & alu_b;
            4'b0001: alu_result = alu_a | alu_b;
            4'b0010: alu_result = alu_a ^ alu_b;
            4'b0011: alu_result = ~(alu_a | alu_b);
            4'b0100: alu_result = alu_a + alu_b;
            4'b0101: alu_result = alu_a - alu_b;
            4'b0110: alu_result = alu_a + 32'd1;
            4'b0111: alu_result = alu_a - 32'd1;
            default: alu_result = '0;
        endcase
        alu_zero = (alu_result == '0);
    end

    // Presents a command, waits for acceptance and checks the one-cycle latency; leaves the DUT in RESP.
    task automatic send_cmd(input string name, input logic [3:0] op, input logic [2:0] rd,
                            input logic [2:0] rs1, input logic [2:0] rs2, input logic use_imm,
                            input logic load, input logic [31:0] imm);
        int waited;
        waited = 0;
        while (!cmd_ready && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        tests++;
        if (!cmd_ready) begin
            fails++;
            $display("FAIL %s ready_timeout: cmd_ready=%0b required 1", name, cmd_ready);
        end
        cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2;
        cmd_use_imm = use_imm; cmd_load = load; cmd_imm = imm;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_op = 4'hF; cmd_rd = 3'd7; cmd_imm = 32'hDEAD_BEEF;
        tests++;
        if (res_valid !== 1'b0) begin
            fails++;
            $display("FAIL %s early_valid: res_valid=%0b required 0", name, res_valid);
        end
        @(posedge clk); #1;
        tests++;
        if (res_valid !== 1'b1) begin
            fails++;
            $display("FAIL %s latency: res_valid=%0b required 1", name, res_valid);
        end
    endtask

    task automatic finish_resp();
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    task automatic run_cmd(input string name, input logic [3:0] op, input logic [2:0] rd,
                           input logic [2:0] rs1, input logic [2:0] rs2, input logic use_imm,
                           input logic load, input logic [31:0] imm,
                           input logic [31:0] exp_data, input logic exp_zero, input logic exp_ill);
        send_cmd(name, op, rd, rs1, rs2, use_imm, load, imm);
        tests++;
        if (res_data !== exp_data || res_zero !== exp_zero || res_illegal !== exp_ill || res_rd !== rd) begin
            fails++;
            $display("FAIL %s result: data=%h zero=%0b ill=%0b rd=%0d required data=%h zero=%0b ill=%0b rd=%0d",
                     name, res_data, res_zero, res_illegal, res_rd, exp_data, exp_zero, exp_ill, rd);
        end
        finish_resp();
    endtask

    // OR with r0 into r0 returns rf[idx] without modifying any register.
    task automatic check_reg(input string name, input logic [2:0] idx, input logic [31:0] exp_val);
        run_cmd(name, 4'b0001, 3'd0, idx, 3'd0, 1'b0, 1'b0, 32'h0, exp_val, (exp_val == 32'h0), 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tests++;
        if (cmd_ready !== 1'b1 || res_valid !== 1'b0 || alu_a !== 32'h0 || alu_b !== 32'h0 ||
            alu_ctrl !== 4'h0 || res_data !== 32'h0 || res_zero !== 1'b0 || res_rd !== 3'd0 ||
            res_illegal !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: ready=%0b valid=%0b a=%h b=%h ctrl=%h data=%h zero=%0b rd=%0d ill=%0b required ready=1 all others 0",
                     cmd_ready, res_valid, alu_a, alu_b, alu_ctrl, res_data, res_zero, res_rd, res_illegal);
        end
    endtask

    task automatic test_load();
        run_cmd("load_r1", 4'b0111, 3'd1, 3'd0, 3'd0, 1'b0, 1'b1, 32'h0000_0005, 32'h0000_0005, 1'b0, 1'b0);
        tests++;
        if (alu_ctrl !== 4'b0000) begin
            fails++;
            $display("FAIL load_ctrl: alu_ctrl=%h required 0", alu_ctrl);
        end
        run_cmd("load_r2", 4'b0000, 3'd2, 3'd0, 3'd0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    endtask

    task automatic test_arith();
        run_cmd("add_r3", 4'b0100, 3'd3, 3'd1, 3'd2, 1'b0, 1'b0, 32'h0, 32'h0000_0004, 1'b0, 1'b0);
        run_cmd("sub_r4", 4'b0101, 3'd4, 3'd1, 3'd1, 1'b0, 1'b0, 32'h0, 32'h0000_0000, 1'b1, 1'b0);
        check_reg("read_r4", 3'd4, 32'h0);
        check_reg("read_r3", 3'd3, 32'h4);
        run_cmd("inc_r5", 4'b0110, 3'd5, 3'd2, 3'd0, 1'b0, 1'b0, 32'h0, 32'h0000_0000, 1'b1, 1'b0);
        send_cmd("xor_imm_r6", 4'b0010, 3'd6, 3'd1, 3'd3, 1'b1, 1'b0, 32'h0000_000F);
        tests++;
        if (res_data !== 32'h0000_000A || alu_b !== 32'h0000_000F || alu_a !== 32'h5 || res_rd !== 3'd6) begin
            fails++;
            $display("FAIL xor_imm_r6: data=%h a=%h b=%h rd=%0d required data=0000000a a=5 b=0000000f rd=6",
                     res_data, alu_a, alu_b, res_rd);
        end
        finish_resp();
        run_cmd("self_rs_rd", 4'b0100, 3'd3, 3'd3, 3'd3, 1'b0, 1'b0, 32'h0, 32'h0000_0008, 1'b0, 1'b0);
    endtask

    task automatic test_illegal();
        run_cmd("illegal_op", 4'b1010, 3'd1, 3'd1, 3'd2, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
        run_cmd("add_r7_after_ill", 4'b0100, 3'd7, 3'd1, 3'd0, 1'b0, 1'b0, 32'h0, 32'h5, 1'b0, 1'b0);
        run_cmd("load_bit3_legal", 4'b1111, 3'd7, 3'd0, 3'd0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_backpressure();
        send_cmd("bp_and", 4'b0000, 3'd6, 3'd6, 3'd2, 1'b0, 1'b0, 32'h0);
        cmd_valid = 1'b1; cmd_op = 4'b0000; cmd_rd = 3'd3; cmd_load = 1'b1; cmd_imm = 32'h0000_DEAD;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            tests++;
            if (res_valid !== 1'b1 || cmd_ready !== 1'b0 || res_data !== 32'h0000_000A ||
                res_zero !== 1'b0 || res_rd !== 3'd6 || res_illegal !== 1'b0) begin
                fails++;
                $display("FAIL bp_hold[%0d]: valid=%0b ready=%0b data=%h zero=%0b rd=%0d required valid=1 ready=0 data=0000000a zero=0 rd=6",
                         i, res_valid, cmd_ready, res_data, res_zero, res_rd);
            end
        end
        cmd_valid = 1'b0; cmd_load = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        tests++;
        if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_release: valid=%0b ready=%0b required valid=0 ready=1", res_valid, cmd_ready);
        end
        check_reg("bp_ignored_r3", 3'd3, 32'h8);
    endtask

    task automatic test_r0();
        run_cmd("load_r0", 4'b0000, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1, 32'h0000_1234, 32'h0000_1234, 1'b0, 1'b0);
        run_cmd("add_r0_r0", 4'b0100, 3'd1, 3'd0, 3'd0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_reset_midflight();
        run_cmd("load_r2_pre", 4'b0000, 3'd2, 3'd0, 3'd0, 1'b0, 1'b1, 32'h0000_0055, 32'h0000_0055, 1'b0, 1'b0);
        send_cmd("load_r3_resp", 4'b0000, 3'd3, 3'd0, 3'd0, 1'b0, 1'b1, 32'h0000_0077);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        tests++;
        if (res_valid !== 1'b0 || cmd_ready !== 1'b1 || res_data !== 32'h0) begin
            fails++;
            $display("FAIL rst_in_resp: valid=%0b ready=%0b data=%h required valid=0 ready=1 data=0",
                     res_valid, cmd_ready, res_data);
        end
        cmd_valid = 1'b1; cmd_op = 4'b0000; cmd_rd = 3'd4; cmd_rs1 = 3'd0; cmd_rs2 = 3'd0;
        cmd_use_imm = 1'b0; cmd_load = 1'b1; cmd_imm = 32'h0000_0099;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        tests++;
        if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL rst_in_exec: valid=%0b ready=%0b required valid=0 ready=1", res_valid, cmd_ready);
        end
        for (int r = 1; r < 8; r++) begin
            check_reg($sformatf("post_rst_r%0d", r), r[2:0], 32'h0);
        end
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 4'h0; cmd_rd = '0; cmd_rs1 = '0; cmd_rs2 = '0;
        cmd_use_imm = 1'b0; cmd_load = 1'b0; cmd_imm = '0; res_ready = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_load();
        test_arith();
        test_illegal();
        test_backpressure();
        test_r0();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
